seg_scan_driver: RTL

Drives the front panel of the washing-machine controller from the display interface produced by the view logic. It takes the three 6-bit display values, the current-stage index and the 10-bit LED word, and produces the physical outputs. The physical outputs are a time-multiplexed 6-digit active-low seven-segment bus and an LED bus in which the current stage's LED blinks. It sits between the view logic and the board pins.

---
 rtl/seg_scan_driver_if.sv | 22 ++
 rtl/seg_scan_driver.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/seg_scan_driver_if.sv
// seg_scan_driver_if: display bundle between the view logic and the
// front-panel scan driver (values/LED word in, panel pins out).
interface seg_scan_driver_if;
   logic [5:0] showLeft;
   logic [5:0] showMiddle;
   logic [5:0] showRight;
   logic [2:0] shinning;
   logic [9:0] LEDMsg;
   logic [5:0] an;
   logic [7:0] seg;
   logic [9:0] led;

   modport master (
      output showLeft, showMiddle, showRight, shinning, LEDMsg,
      input  an, seg, led
   );

   modport slave (
      input  showLeft, showMiddle, showRight, shinning, LEDMsg,
      output an, seg, led
   );
endinterface

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: 6-digit active-low multiplexed 7-seg scanner with
// per-frame value latch, BCD split, blanking, dp and blinking stage LED.
module seg_scan_driver #(
   parameter int SCAN_DIV  = 50000,
   parameter int BLINK_DIV = 25000000
) (
   input logic             cp,
   input logic             reset,
   seg_scan_driver_if.slave dif
);

   localparam int SW = $clog2(SCAN_DIV);
   localparam int BW = $clog2(BLINK_DIV);
   localparam logic [SW-1:0] SCAN_TC  = SW'(SCAN_DIV - 1);
   localparam logic [BW-1:0] BLINK_TC = BW'(BLINK_DIV - 1);

   logic [SW-1:0] scnt_q, scnt_d;
   logic [2:0]    d_q, d_d;
   logic [BW-1:0] bcnt_q, bcnt_d;
   logic          phase_q, phase_d;
   logic          first_q;
   logic [5:0]    shl_q, shm_q, shr_q;
   logic [5:0]    an_q, an_d;
   logic [7:0]    seg_q, seg_d;
   logic [9:0]    led_q, led_d;

   logic          scan_wrap;
   logic          latch;
   logic [5:0]    src_l, src_m, src_r;
   logic [5:0]    val;
   logic          is_units;
   logic [12:0]   prod;
   logic [2:0]    tens;
   logic [5:0]    rem;
   logic [3:0]    digit;
   logic          blank;
   logic [2:0]    lidx;

   function automatic logic [6:0] seg_code(input logic [3:0] n);
      logic [6:0] c;
      case (n)
         4'd0:    c = 7'b1000000;
         4'd1:    c = 7'b1111001;
         4'd2:    c = 7'b0100100;
         4'd3:    c = 7'b0110000;
         4'd4:    c = 7'b0011001;
         4'd5:    c = 7'b0010010;
         4'd6:    c = 7'b0000010;
         4'd7:    c = 7'b1111000;
         4'd8:    c = 7'b0000000;
         4'd9:    c = 7'b0010000;
         default: c = 7'b1111111;
      endcase
      return c;
   endfunction

   assign scan_wrap = (scnt_q == SCAN_TC);
   assign latch     = first_q | (scan_wrap & (d_q == 3'd5));

   // The very first step after reset shows the live inputs, because
   // the shadows are only being loaded on that same edge.
   assign src_l = first_q ? dif.showLeft   : shl_q;
   assign src_m = first_q ? dif.showMiddle : shm_q;
   assign src_r = first_q ? dif.showRight  : shr_q;

   // Scan and blink counters advance independently.
   always_comb begin
      scnt_d  = scan_wrap ? '0 : scnt_q + SW'(1);
      d_d     = d_q;
      if (scan_wrap)
         d_d = (d_q == 3'd5) ? 3'd0 : d_q + 3'd1;
      bcnt_d  = bcnt_q + BW'(1);
      phase_d = phase_q;
      if (bcnt_q == BLINK_TC) begin
         bcnt_d  = '0;
         phase_d = ~phase_q;
      end
   end

   // Select the value and digit kind for the current scan slot.
   always_comb begin
      val      = '0;
      is_units = 1'b0;
      unique case (d_q)
         3'd0: begin val = src_l; is_units = 1'b0; end
         3'd1: begin val = src_l; is_units = 1'b1; end
         3'd2: begin val = src_m; is_units = 1'b0; end
         3'd3: begin val = src_m; is_units = 1'b1; end
         3'd4: begin val = src_r; is_units = 1'b0; end
         3'd5: begin val = src_r; is_units = 1'b1; end
         default: begin val = '0; is_units = 1'b0; end
      endcase
   end

   // v/10 as (v*13)>>7 is exact over 0..63; units is the remainder.
   always_comb begin
      prod  = {7'd0, val} * 13'd13;
      tens  = prod[9:7];
      rem   = val - ({3'd0, tens} * 6'd10);
      digit = is_units ? rem[3:0] : {1'b0, tens};
      blank = ~is_units & (tens == 3'd0);
   end

   // Next panel outputs: digit enable, segments and blinking LED word.
   always_comb begin
      an_d  = ~(6'b100000 >> d_q);
      seg_d = {~(is_units & dif.LEDMsg[9]), seg_code(digit)};
      if (blank)
         seg_d = 8'hFF;
      if (!dif.LEDMsg[8]) begin
         an_d  = 6'h3F;
         seg_d = 8'hFF;
      end
      lidx  = 3'd7 - dif.shinning;
      led_d = dif.LEDMsg;
      if (dif.LEDMsg[8] && !dif.LEDMsg[9])
         led_d[lidx] = dif.LEDMsg[lidx] & phase_q;
   end

   // Counter, phase and first-step flag registers.
   always_ff @(posedge cp or posedge reset) begin
      if (reset) begin
         scnt_q  <= '0;
         d_q     <= 3'd0;
         bcnt_q  <= '0;
         phase_q <= 1'b1;
         first_q <= 1'b1;
      end else begin
         scnt_q  <= scnt_d;
         d_q     <= d_d;
         bcnt_q  <= bcnt_d;
         phase_q <= phase_d;
         first_q <= 1'b0;
      end
   end

   // Frame shadows: loaded only at frame start so a frame never mixes values.
   always_ff @(posedge cp or posedge reset) begin
      if (reset) begin
         shl_q <= '0;
         shm_q <= '0;
         shr_q <= '0;
      end else if (latch) begin
         shl_q <= dif.showLeft;
         shm_q <= dif.showMiddle;
         shr_q <= dif.showRight;
      end
   end

   // Registered panel outputs.
   always_ff @(posedge cp or posedge reset) begin
      if (reset) begin
         an_q  <= 6'h3F;
         seg_q <= 8'hFF;
         led_q <= 10'h000;
      end else begin
         an_q  <= an_d;
         seg_q <= seg_d;
         led_q <= led_d;
      end
   end

   assign dif.an  = an_q;
   assign dif.seg = seg_q;
   assign dif.led = led_q;

endmodule
